// File: rtl/debounce4_stage.sv
// Four-channel synchronizer + debouncer feeding the 4-input AND gate.
// Build option: define SYNC_3FF_EN for a 3-flop synchronizer instead of 2.
module debounce4_stage #(
    parameter int unsigned STABLE_CYCLES = 10,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw0,
    input  logic       raw1,
    input  logic       raw2,
    input  logic       raw3,
    output logic       out0,
    output logic       out1,
    output logic       out2,
    output logic       out3,
    output logic [3:0] chg,
    output logic       any_chg
);

`ifdef SYNC_3FF_EN
    localparam int unsigned SYNC_N = 3;
`else
    localparam int unsigned SYNC_N = 2;
`endif
    localparam int unsigned       NCH        = 4;
    localparam longint unsigned   MAX_STABLE = 64'd1 << CNT_W;
    localparam logic [CNT_W-1:0]  LAST       = CNT_W'(STABLE_CYCLES - 1);

    // The counter must reach STABLE_CYCLES-1 without wrapping.
    generate
        if ((STABLE_CYCLES < 1) || (64'(STABLE_CYCLES) > MAX_STABLE)) begin : g_bad_cfg
            $error("debounce4_stage: STABLE_CYCLES must be in 1..2**CNT_W");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    logic [NCH-1:0]   raw_c;
    logic [NCH-1:0]   sync_q [SYNC_N];
    logic [NCH-1:0]   s_c;
    state_t           state_q [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [NCH-1:0]   out_q;
    logic [NCH-1:0]   flip_c;

    assign raw_c = {raw3, raw2, raw1, raw0};
    assign s_c   = sync_q[SYNC_N-1];

    // Plain flop chain, nothing between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned j = 0; j < SYNC_N; j++) begin
                sync_q[j] <= '0;
            end
        end else begin
            sync_q[0] <= raw_c;
            for (int unsigned j = 1; j < SYNC_N; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
        end
    end

    // A channel flips when it has mismatched for the full stability window.
    always_comb begin
        flip_c = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            flip_c[i] = (s_c[i] != out_q[i]) && (cnt_q[i] == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            out_q   <= '0;
            chg     <= '0;
            any_chg <= 1'b0;
        end else begin
            chg     <= flip_c;
            any_chg <= |flip_c;
            for (int unsigned i = 0; i < NCH; i++) begin
                case (state_q[i])
                    IDLE: begin
                        if (s_c[i] != out_q[i]) begin
                            if (flip_c[i]) begin
                                out_q[i] <= s_c[i];
                                cnt_q[i] <= '0;
                            end else begin
                                cnt_q[i]   <= cnt_q[i] + CNT_W'(1);
                                state_q[i] <= COUNT;
                            end
                        end else begin
                            cnt_q[i] <= '0;
                        end
                    end
                    COUNT: begin
                        if (s_c[i] == out_q[i]) begin
                            state_q[i] <= IDLE;
                            cnt_q[i]   <= '0;
                        end else if (flip_c[i]) begin
                            out_q[i]   <= s_c[i];
                            cnt_q[i]   <= '0;
                            state_q[i] <= IDLE;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign out0 = out_q[0];
    assign out1 = out_q[1];
    assign out2 = out_q[2];
    assign out3 = out_q[3];

endmodule
